// File: rtl/axi_csr_bank_if.sv
// AXI4-Lite slave bundle for the CSR bank.
// Carries the five channels between the host interconnect and axi_csr_bank.
interface axi_csr_bank_if #(
    parameter int C_ADDR_WIDTH = 6,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_csr_bank.sv
// Parametrised AXI4-Lite control/status register bank feeding the DMA engine:
// CTRL with self-clearing start bit, live STATUS, W1C IRQ status, IRQ enable, config block.
module axi_csr_bank #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_REGS   = 16,
    parameter int C_ADDR_WIDTH = 6
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    axi_csr_bank_if.slave                          s_axi,
    output logic [C_DATA_WIDTH-1:0]                ctrl_out,
    output logic                                   start_pulse,
    input  logic [C_DATA_WIDTH-1:0]                status_in,
    input  logic [C_DATA_WIDTH-1:0]                irq_event_in,
    output logic                                   irq,
    output logic [(C_NUM_REGS-4)*C_DATA_WIDTH-1:0] cfg_out
);
    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = C_ADDR_WIDTH - LSB;
    localparam int SEL_W  = $clog2(C_NUM_REGS);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;

    logic [1:0]              r_rstSync;
    logic                    w_rstN;
    wstate_t                 r_wState, w_wStateNext;
    logic                    w_awReady, w_wReady, w_commit;
    logic                    r_awHeld, r_wHeld;
    logic [C_ADDR_WIDTH-1:0] r_awAddr;
    logic [C_DATA_WIDTH-1:0] r_wData;
    logic [STRB_W-1:0]       r_wStrb;
    logic [1:0]              r_bResp;
    logic                    r_startPulse, r_irq;
    logic [C_DATA_WIDTH-1:0] r_regs [C_NUM_REGS];
    logic [IDX_W-1:0]        w_wIdx, w_rIdx;
    logic [SEL_W-1:0]        w_rSel;
    logic                    w_wInRange, w_rInRange, w_arReady;
    logic [C_DATA_WIDTH-1:0] w_strbMask, w_w1cMask, w_rdMux;
    logic                    r_rValid;
    logic [C_DATA_WIDTH-1:0] r_rData;
    logic [1:0]              r_rResp;
    logic                    w_unused;

    // Reset asserts asynchronously but releases on a clock edge; READYs are gated so they stay low in reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_rstSync <= '0;
        else          r_rstSync <= {r_rstSync[0], 1'b1};
    end
    assign w_rstN = r_rstSync[1];

    assign w_wIdx     = r_awAddr[C_ADDR_WIDTH-1:LSB];
    assign w_rIdx     = s_axi.S_AXI_ARADDR[C_ADDR_WIDTH-1:LSB];
    assign w_rSel     = w_rIdx[SEL_W-1:0];
    assign w_wInRange = (32'(w_wIdx) < 32'(C_NUM_REGS));
    assign w_rInRange = (32'(w_rIdx) < 32'(C_NUM_REGS));

    always_ff @(posedge ACLK or negedge w_rstN) begin
        if (!w_rstN) r_wState <= W_IDLE;
        else         r_wState <= w_wStateNext;
    end

    always_comb begin
        w_wStateNext = r_wState;
        w_awReady    = 1'b0;
        w_wReady     = 1'b0;
        w_commit     = 1'b0;
        case (r_wState)
            W_IDLE: begin
                w_awReady = w_rstN && !r_awHeld;
                w_wReady  = w_rstN && !r_wHeld;
                if (r_awHeld && r_wHeld) begin
                    w_commit     = 1'b1;
                    w_wStateNext = W_RESP;
                end
            end
            W_RESP: if (s_axi.S_AXI_BREADY) w_wStateNext = W_IDLE;
            default: w_wStateNext = W_IDLE;
        endcase
    end

    // AW and W are latched independently; the commit empties both holding slots.
    always_ff @(posedge ACLK or negedge w_rstN) begin
        if (!w_rstN) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_awAddr <= '0;
            r_wData  <= '0;
            r_wStrb  <= '0;
            r_bResp  <= 2'b00;
        end else begin
            if (w_awReady && s_axi.S_AXI_AWVALID) begin
                r_awHeld <= 1'b1;
                r_awAddr <= s_axi.S_AXI_AWADDR;
            end
            if (w_wReady && s_axi.S_AXI_WVALID) begin
                r_wHeld <= 1'b1;
                r_wData <= s_axi.S_AXI_WDATA;
                r_wStrb <= s_axi.S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_awHeld <= 1'b0;
                r_wHeld  <= 1'b0;
                r_bResp  <= w_wInRange ? 2'b00 : 2'b10;
            end
        end
    end

    always_comb begin
        w_strbMask = '0;
        for (int b = 0; b < STRB_W; b++) w_strbMask[b*8 +: 8] = {8{r_wStrb[b]}};
    end

    assign w_w1cMask = (w_commit && w_wInRange && w_wIdx == IDX_W'(2)) ? (r_wData & w_strbMask) : '0;

    // IRQ status is rewritten every cycle so a hardware event always beats a same-cycle software clear.
    always_ff @(posedge ACLK or negedge w_rstN) begin
        if (!w_rstN) begin
            for (int i = 0; i < C_NUM_REGS; i++) r_regs[i] <= '0;
            r_startPulse <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (i == 2) begin
                    r_regs[i] <= (r_regs[i] & ~w_w1cMask) | irq_event_in;
                end else if (i != 1 && w_commit && w_wInRange && w_wIdx == IDX_W'(i)) begin
                    r_regs[i] <= (r_regs[i] & ~w_strbMask) | (r_wData & w_strbMask);
                    if (i == 0) r_regs[i][0] <= 1'b0;
                end
            end
            r_startPulse <= w_commit && w_wInRange && (w_wIdx == '0) && r_wStrb[0] && r_wData[0];
            r_irq        <= |(r_regs[2] & r_regs[3]);
        end
    end

    assign w_arReady = w_rstN && !r_rValid;

    always_comb begin
        w_rdMux = r_regs[w_rSel];
        if (w_rIdx == IDX_W'(1)) w_rdMux = status_in;
    end

    always_ff @(posedge ACLK or negedge w_rstN) begin
        if (!w_rstN) begin
            r_rValid <= 1'b0;
            r_rData  <= '0;
            r_rResp  <= 2'b00;
        end else if (w_arReady && s_axi.S_AXI_ARVALID) begin
            r_rValid <= 1'b1;
            r_rData  <= w_rInRange ? w_rdMux : '0;
            r_rResp  <= w_rInRange ? 2'b00 : 2'b10;
        end else if (r_rValid && s_axi.S_AXI_RREADY) begin
            r_rValid <= 1'b0;
        end
    end

    assign s_axi.S_AXI_AWREADY = w_awReady;
    assign s_axi.S_AXI_WREADY  = w_wReady;
    assign s_axi.S_AXI_BVALID  = (r_wState == W_RESP);
    assign s_axi.S_AXI_BRESP   = r_bResp;
    assign s_axi.S_AXI_ARREADY = w_arReady;
    assign s_axi.S_AXI_RVALID  = r_rValid;
    assign s_axi.S_AXI_RDATA   = r_rData;
    assign s_axi.S_AXI_RRESP   = r_rResp;

    assign ctrl_out    = r_regs[0];
    assign start_pulse = r_startPulse;
    assign irq         = r_irq;

    for (genvar g = 4; g < C_NUM_REGS; g++) begin : g_cfg
        assign cfg_out[(g-4)*C_DATA_WIDTH +: C_DATA_WIDTH] = r_regs[g];
    end

    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        r_awAddr[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};
endmodule

// File: tb/tb_axi_csr_bank.sv
// Directed bench for axi_csr_bank: reads are scoreboarded against expected values
// queued when each read is issued; every comparison is an immediate assertion.
module tb_axi_csr_bank;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NR = 16;

    logic                 ACLK = 1'b0;
    logic                 ARESETN = 1'b0;
    logic [DW-1:0]        ctrl_out;
    logic                 start_pulse;
    logic [DW-1:0]        status_in;
    logic [DW-1:0]        irq_event_in;
    logic                 irq;
    logic [(NR-4)*DW-1:0] cfg_out;

    int checks   = 0;
    int failures = 0;
    int pulseCnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       tag;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] model[NR];

    always #5 ACLK = ~ACLK;

    axi_csr_bank_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    axi_csr_bank #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW)) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .s_axi        (bus.slave),
        .ctrl_out     (ctrl_out),
        .start_pulse  (start_pulse),
        .status_in    (status_in),
        .irq_event_in (irq_event_in),
        .irq          (irq),
        .cfg_out      (cfg_out)
    );

    // Each cycle start_pulse is seen high adds one, so a clean pulse counts exactly 1.
    always @(negedge ACLK) if (start_pulse === 1'b1) pulseCnt++;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idleBus();
        bus.S_AXI_AWADDR  = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
    endtask

    // One complete write: AW and W offered together, then B collected.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [1:0] resp);
        bit awDone, wDone, awHs, wHs;
        int n;
        awDone = 0; wDone = 0; n = 0;
        @(negedge ACLK);
        bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA  = data; bus.S_AXI_WSTRB   = strb; bus.S_AXI_WVALID = 1'b1;
        while (!(awDone && wDone) && n < 40) begin
            awHs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            wHs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge ACLK);
            n++;
            if (awHs) begin awDone = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (wHs)  begin wDone  = 1; bus.S_AXI_WVALID  = 1'b0; end
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        n = 0;
        while (bus.S_AXI_BVALID !== 1'b1 && n < 40) begin @(negedge ACLK); n++; end
        checkOutput("wr_bvalid_bound", 64'(n < 40), 64'(1));
        resp = bus.S_AXI_BRESP;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axiRead(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge ACLK);
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
        while (bus.S_AXI_ARREADY !== 1'b1 && n < 40) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        bus.S_AXI_ARVALID = 1'b0;
        while (bus.S_AXI_RVALID !== 1'b1 && n < 40) begin @(negedge ACLK); n++; end
        checkOutput("rd_rvalid_bound", 64'(n < 40), 64'(1));
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic readExpect(input logic [AW-1:0] addr, input logic [31:0] expData,
                              input logic [1:0] expResp, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        exp_t        e;
        sbq.push_back('{data: expData, resp: expResp, tag: tag});
        axiRead(addr, d, r);
        e = sbq.pop_front();
        checkOutput({e.tag, "_data"}, 64'(d), 64'(e.data));
        checkOutput({e.tag, "_resp"}, 64'(r), 64'(e.resp));
    endtask

    initial begin
        logic [1:0] resp;
        int         n;
        int         bHigh;

        idleBus();
        status_in    = 32'hCAFE_0001;
        irq_event_in = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        repeat (3) @(negedge ACLK);
        checkOutput("rst_awready", 64'(bus.S_AXI_AWREADY), 64'(0));
        checkOutput("rst_wready",  64'(bus.S_AXI_WREADY),  64'(0));
        checkOutput("rst_arready", 64'(bus.S_AXI_ARREADY), 64'(0));
        checkOutput("rst_bvalid",  64'(bus.S_AXI_BVALID),  64'(0));
        checkOutput("rst_rvalid",  64'(bus.S_AXI_RVALID),  64'(0));
        checkOutput("rst_rdata",   64'(bus.S_AXI_RDATA),   64'(0));
        checkOutput("rst_irq",     64'(irq),               64'(0));
        checkOutput("rst_start",   64'(start_pulse),       64'(0));
        checkOutput("rst_ctrl",    64'(ctrl_out),          64'(0));
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);
        checkOutput("post_rst_awready", 64'(bus.S_AXI_AWREADY), 64'(1));

        readExpect(7'h04, 32'hCAFE_0001, 2'b00, "status_live");
        applyStimulus(7'h04, 32'h5555_5555, 4'hF, resp);
        checkOutput("status_wr_bresp", 64'(resp), 64'(0));
        readExpect(7'h04, 32'hCAFE_0001, 2'b00, "status_ro");

        for (int i = 4; i < NR; i++) begin
            applyStimulus(AW'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF, resp);
            checkOutput($sformatf("cfg%0d_bresp", i), 64'(resp), 64'(0));
            model[i] = 32'hA5A5_0000 + 32'(i);
        end
        for (int i = 4; i < NR; i++) begin
            readExpect(AW'(i * 4), model[i], 2'b00, $sformatf("cfg%0d", i));
            checkOutput($sformatf("cfg%0d_out", i), 64'(cfg_out[(i-4)*DW +: DW]), 64'(model[i]));
        end

        applyStimulus(7'h14, 32'h1234_5678, 4'hF, resp);
        applyStimulus(7'h14, 32'hFFFF_FFFF, 4'b0010, resp);
        model[5] = 32'h1234_FF78;
        readExpect(7'h14, 32'h1234_FF78, 2'b00, "strb_lane1");

        pulseCnt = 0;
        applyStimulus(7'h00, 32'h0000_0003, 4'hF, resp);
        repeat (2) @(negedge ACLK);
        checkOutput("start_pulse_once", 64'(pulseCnt), 64'(1));
        readExpect(7'h00, 32'h0000_0002, 2'b00, "ctrl_rd");
        checkOutput("ctrl_out", 64'(ctrl_out), 64'(2));
        pulseCnt = 0;
        applyStimulus(7'h00, 32'h0000_0001, 4'b1110, resp);
        repeat (2) @(negedge ACLK);
        checkOutput("start_no_lane0", 64'(pulseCnt), 64'(0));
        checkOutput("ctrl_lane0_kept", 64'(ctrl_out), 64'(2));

        applyStimulus(7'h0C, 32'h0000_0008, 4'hF, resp);
        @(negedge ACLK); irq_event_in = 32'h8;
        @(negedge ACLK); irq_event_in = '0;
        repeat (2) @(negedge ACLK);
        checkOutput("irq_set", 64'(irq), 64'(1));
        readExpect(7'h08, 32'h0000_0008, 2'b00, "irqsts_set");
        applyStimulus(7'h08, 32'h0000_0008, 4'hF, resp);
        repeat (2) @(negedge ACLK);
        readExpect(7'h08, 32'h0000_0000, 2'b00, "irqsts_w1c");
        checkOutput("irq_clr", 64'(irq), 64'(0));

        // Event lands on the commit edge: AW/W taken at edge 1, commit at edge 2.
        @(negedge ACLK);
        bus.S_AXI_AWADDR = 7'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA  = 32'h8; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        irq_event_in = 32'h8;
        @(negedge ACLK);
        irq_event_in = '0;
        checkOutput("race_bvalid", 64'(bus.S_AXI_BVALID), 64'(1));
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
        readExpect(7'h08, 32'h0000_0008, 2'b00, "irqsts_hw_wins");
        checkOutput("irq_hw_wins", 64'(irq), 64'(1));

        applyStimulus(7'h40, 32'hDEAD_BEEF, 4'hF, resp);
        checkOutput("oor_bresp", 64'(resp), 64'(2));
        readExpect(7'h40, 32'h0000_0000, 2'b10, "oor_rd");
        readExpect(7'h10, model[4], 2'b00, "oor_reg4_kept");
        checkOutput("oor_ctrl_kept", 64'(ctrl_out), 64'(2));

        @(negedge ACLK);
        bus.S_AXI_AWADDR = 7'h18;
        bus.S_AXI_WDATA  = 32'h0BAD_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_WVALID = 1'b0;
        checkOutput("w_first_wready", 64'(bus.S_AXI_WREADY), 64'(0));
        repeat (2) @(negedge ACLK);
        checkOutput("w_first_awready", 64'(bus.S_AXI_AWREADY), 64'(1));
        checkOutput("w_first_nobvalid", 64'(bus.S_AXI_BVALID), 64'(0));
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0;
        n = 0;
        while (bus.S_AXI_BVALID !== 1'b1 && n < 40) begin @(negedge ACLK); n++; end
        checkOutput("w_first_bvalid_bound", 64'(n < 40), 64'(1));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bhold%0d", k),
                        64'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 64'(3'b100));
            @(negedge ACLK);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_BREADY = 1'b0;
        checkOutput("b_released", 64'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY}), 64'(2'b01));
        readExpect(7'h18, 32'h0BAD_F00D, 2'b00, "w_first_rd");

        @(negedge ACLK);
        bus.S_AXI_AWADDR = 7'h1C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA  = 32'h7777_7777; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        bHigh = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge ACLK);
            if (bus.S_AXI_BVALID === 1'b1) bHigh++;
        end
        checkOutput("abort_no_bresp", 64'(bHigh), 64'(0));
        readExpect(7'h1C, 32'h0000_0000, 2'b00, "abort_reg7");
        readExpect(7'h18, 32'h0000_0000, 2'b00, "abort_reg6_reset");
        checkOutput("abort_irq", 64'(irq), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
